// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// This covers address-width derivation, packed-port widths and the
// read-bypass source select.
package regfile_pkg;

  // Ceiling log2, used to derive the register address width from NREG.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Width of the packed read-address bus.
  function automatic int rd_addr_w(input int nrd, input int aw);
    return nrd * aw;
  endfunction

  // Width of the packed read-data bus.
  function automatic int rd_data_w(input int nrd, input int dw);
    return nrd * dw;
  endfunction

  // Width of the flattened register array passed to the read ports.
  function automatic int rf_flat_w(input int nreg, input int dw);
    return nreg * dw;
  endfunction

  // Source selected by a read port: stored value or one of the write ports.
  typedef enum logic [1:0] {
    WSRC_RF = 2'd0,
    WSRC_W0 = 2'd1,
    WSRC_W1 = 2'd2
  } wsrc_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port.
// It performs a write-first bypass from both write ports, with w0 taking
// priority over w1. Register 0 always reads as zero and is never busy.
// Both outputs are forced to zero while en_i is low, which is the case
// during reset.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5
) (
  input  logic                              en_i,
  input  logic [AW-1:0]                     addr_i,
  input  logic [rf_flat_w(NREG,DATA_W)-1:0] rf_i,
  input  logic [NREG-1:0]                   busy_i,
  input  logic                              w0_en_i,
  input  logic [AW-1:0]                     w0_addr_i,
  input  logic [DATA_W-1:0]                 w0_data_i,
  input  logic                              w1_en_i,
  input  logic [AW-1:0]                     w1_addr_i,
  input  logic [DATA_W-1:0]                 w1_data_i,
  output logic [DATA_W-1:0]                 data_o,
  output logic                              busy_o
);

  wsrc_e             wsrc;
  logic              addr_nz;
  logic              w0_hit;
  logic              w1_hit;
  logic [DATA_W-1:0] stored;

  assign addr_nz = (addr_i != '0);
  assign w0_hit  = w0_en_i && (w0_addr_i == addr_i) && addr_nz;
  assign w1_hit  = w1_en_i && (w1_addr_i == addr_i) && addr_nz;
  assign stored  = rf_i[int'(addr_i)*DATA_W +: DATA_W];

  // Pick the bypass source; w0 overrides w1 when both hit this address.
  always_comb begin
    wsrc = WSRC_RF;
    if (w1_hit) begin
      wsrc = WSRC_W1;
    end
    if (w0_hit) begin
      wsrc = WSRC_W0;
    end
  end

  // Drive read data and busy status, both gated off while disabled.
  always_comb begin
    data_o = '0;
    busy_o = 1'b0;
    if (en_i) begin
      case (wsrc)
        WSRC_W0: data_o = w0_data_i;
        WSRC_W1: data_o = w1_data_i;
        default: data_o = stored;
      endcase
      // A load writing back this cycle already hides the busy flag.
      busy_o = busy_i[addr_i] && !w1_hit && addr_nz;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with a load scoreboard.
// Port w0 is the ALU write port. Port w1 is the load writeback port, and it
// also clears the busy flag of its target. sb_set marks a register busy when
// a load issues. sb_err pulses when a load targets a register that is
// already pending.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  localparam int AW    = clog2(NREG)
) (
  input  logic                             clk,
  input  logic                             clrn,
  input  logic [rd_addr_w(NRD,AW)-1:0]     rd_addr,
  output logic [rd_data_w(NRD,DATA_W)-1:0] rd_data,
  output logic [NRD-1:0]                   rd_busy,
  input  logic                             w0_en,
  input  logic [AW-1:0]                    w0_addr,
  input  logic [DATA_W-1:0]                w0_data,
  input  logic                             w1_en,
  input  logic [AW-1:0]                    w1_addr,
  input  logic [DATA_W-1:0]                w1_data,
  input  logic                             sb_set_en,
  input  logic [AW-1:0]                    sb_set_addr,
  output logic                             sb_err
);

  logic [rf_flat_w(NREG,DATA_W)-1:0] rf_flat;
  logic [NREG-1:0]                   busy_q;
  logic [NREG-1:0]                   busy_d;
  logic                              sb_err_q;
  logic                              sb_err_d;
  logic                              set_nz;
  logic                              set_cleared;

  // Register 0 is hardwired to zero and never stored.
  assign rf_flat[DATA_W-1:0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      logic [DATA_W-1:0] val_q;
      logic [DATA_W-1:0] val_d;

      // Next value: w0 wins over w1 when both target this register.
      always_comb begin
        val_d = val_q;
        if (w1_en && (w1_addr == AW'(gi))) begin
          val_d = w1_data;
        end
        if (w0_en && (w0_addr == AW'(gi))) begin
          val_d = w0_data;
        end
      end

      // Storage flop, cleared asynchronously on reset.
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          val_q <= '0;
        end else begin
          val_q <= val_d;
        end
      end

      assign rf_flat[gi*DATA_W +: DATA_W] = val_q;
    end
  endgenerate

  assign set_nz      = sb_set_en && (sb_set_addr != '0);
  assign set_cleared = w1_en && (w1_addr == sb_set_addr);

  // Scoreboard next state: the w1 clear is applied first so that a
  // coincident set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (w1_en) begin
      busy_d[w1_addr] = 1'b0;
    end
    if (set_nz) begin
      busy_d[sb_set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
    sb_err_d  = set_nz && busy_q[sb_set_addr] && !set_cleared;
  end

  // Scoreboard and error-pulse flops.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      regfile_rdport #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
      ) u_rdport (
        .en_i      (clrn),
        .addr_i    (rd_addr[gi*AW +: AW]),
        .rf_i      (rf_flat),
        .busy_i    (busy_q),
        .w0_en_i   (w0_en),
        .w0_addr_i (w0_addr),
        .w0_data_i (w0_data),
        .w1_en_i   (w1_en),
        .w1_addr_i (w1_addr),
        .w1_data_i (w1_data),
        .data_o    (rd_data[gi*DATA_W +: DATA_W]),
        .busy_o    (rd_busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb.
// It applies a table of per-cycle vectors to a default-parameter instance
// through an expected-value queue, then runs hand-written reset sequences
// on that instance and on a 4-port, 16-register, 16-bit instance.
module tb_regfile_sb;

  logic clk;
  logic clrn_a;
  logic clrn_b;

  // Instance A: default parameters (32-bit, 32 regs, 2 read ports)
  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic        w0_en_a, w1_en_a, set_en_a, sb_err_a;
  logic [4:0]  w0_addr_a, w1_addr_a, set_addr_a;
  logic [31:0] w0_data_a, w1_data_a;

  // Instance B: NRD=4, NREG=16, DATA_W=16
  logic [15:0] rd_addr_b;
  logic [63:0] rd_data_b;
  logic [3:0]  rd_busy_b;
  logic        w0_en_b, w1_en_b, set_en_b, sb_err_b;
  logic [3:0]  w0_addr_b, w1_addr_b, set_addr_b;
  logic [15:0] w0_data_b, w1_data_b;

  int n_vec;
  int n_fail;

  regfile_sb u_dut_a (
    .clk(clk), .clrn(clrn_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .w0_en(w0_en_a), .w0_addr(w0_addr_a), .w0_data(w0_data_a),
    .w1_en(w1_en_a), .w1_addr(w1_addr_a), .w1_data(w1_data_a),
    .sb_set_en(set_en_a), .sb_set_addr(set_addr_a), .sb_err(sb_err_a)
  );

  regfile_sb #(.DATA_W(16), .NREG(16), .NRD(4)) u_dut_b (
    .clk(clk), .clrn(clrn_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .w0_en(w0_en_b), .w0_addr(w0_addr_b), .w0_data(w0_data_b),
    .w1_en(w1_en_b), .w1_addr(w1_addr_b), .w1_data(w1_data_b),
    .sb_set_en(set_en_b), .sb_set_addr(set_addr_b), .sb_err(sb_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
    logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
    logic        se;  logic [4:0] sa;
    logic [4:0]  ra0; logic [4:0] ra1;
    logic [31:0] ed0; logic [31:0] ed1; logic [1:0] eb; logic ee;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] d0; logic [31:0] d1; logic [1:0] b; logic e;
  } exp_t;

  localparam int NV = 23;
  vec_t vecs[NV];
  exp_t exp_q[$];

  function automatic vec_t mk(
    input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
    input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
    input logic se,  input logic [4:0] sa,
    input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [31:0] ed0, input logic [31:0] ed1,
    input logic [1:0] eb, input logic ee);
    vec_t v;
    v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
    v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
    v.se = se; v.sa = sa; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic idle_a();
    w0_en_a = 0; w0_addr_a = '0; w0_data_a = '0;
    w1_en_a = 0; w1_addr_a = '0; w1_data_a = '0;
    set_en_a = 0; set_addr_a = '0;
  endtask

  task automatic idle_b();
    w0_en_b = 0; w0_addr_b = '0; w0_data_b = '0;
    w1_en_b = 0; w1_addr_b = '0; w1_data_b = '0;
    set_en_b = 0; set_addr_b = '0;
  endtask

  initial begin
    exp_t e;
    string nm;
    n_vec = 0;
    n_fail = 0;
    clrn_a = 0;
    clrn_b = 0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    idle_a();
    idle_b();

    //             w0e w0a  w0d           w1e w1a  w1d          se sa  ra0 ra1 ed0           ed1           eb     ee
    vecs[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 0, 5, 32'h0,        32'h0,        2'b00, 0);
    vecs[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,     0, 0, 5, 0, 32'hDEADBEEF, 32'h0,        2'b00, 0);
    vecs[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
    vecs[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,     1, 7, 7, 0, 32'h0,        32'h0,        2'b00, 0);
    vecs[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 7, 0, 32'h0,        32'h0,        2'b01, 0);
    vecs[5]  = mk(1, 7, 32'h11,       1, 7, 32'h22,    0, 0, 7, 0, 32'h11,       32'h0,        2'b00, 0);
    vecs[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 7, 7, 32'h11,       32'h11,       2'b00, 0);
    vecs[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,     1, 3, 3, 7, 32'h0,        32'h11,       2'b00, 0);
    vecs[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 3, 7, 32'h0,        32'h11,       2'b01, 0);
    vecs[9]  = mk(0, 0, 32'h0,        1, 3, 32'hCAFE,  0, 0, 3, 3, 32'hCAFE,     32'hCAFE,     2'b00, 0);
    vecs[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 3, 3, 32'hCAFE,     32'hCAFE,     2'b00, 0);
    vecs[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,     1, 3, 3, 0, 32'hCAFE,     32'h0,        2'b00, 0);
    vecs[12] = mk(0, 0, 32'h0,        0, 0, 32'h0,     1, 3, 3, 0, 32'hCAFE,     32'h0,        2'b01, 0);
    vecs[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 3, 0, 32'hCAFE,     32'h0,        2'b01, 1);
    vecs[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 3, 0, 32'hCAFE,     32'h0,        2'b01, 0);
    vecs[15] = mk(0, 0, 32'h0,        1, 3, 32'h33,    1, 3, 3, 0, 32'h33,       32'h0,        2'b00, 0);
    vecs[16] = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 3, 0, 32'h33,       32'h0,        2'b01, 0);
    vecs[17] = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 3, 0, 32'h33,       32'h0,        2'b01, 0);
    vecs[18] = mk(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h0,     32'h0,        2'b00, 0);
    vecs[19] = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 0);
    vecs[20] = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 0);
    vecs[21] = mk(1, 3, 32'h44,       0, 0, 32'h0,     0, 0, 3, 3, 32'h44,       32'h44,       2'b11, 0);
    vecs[22] = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 3, 3, 32'h44,       32'h44,       2'b11, 0);

    // Outputs must be zero while reset is held.
    #2;
    chk("rst_a_data", {32'h0, rd_data_a}, 64'h0);
    chk("rst_a_busy", {62'h0, rd_busy_a}, 64'h0);
    chk("rst_a_err",  {63'h0, sb_err_a},  64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn_a = 1;
    clrn_b = 1;

    // Table vectors: drive after the edge, check at the following negedge.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      w0_en_a = vecs[i].w0e; w0_addr_a = vecs[i].w0a; w0_data_a = vecs[i].w0d;
      w1_en_a = vecs[i].w1e; w1_addr_a = vecs[i].w1a; w1_data_a = vecs[i].w1d;
      set_en_a = vecs[i].se; set_addr_a = vecs[i].sa;
      rd_addr_a = {vecs[i].ra1, vecs[i].ra0};
      e.idx = i; e.d0 = vecs[i].ed0; e.d1 = vecs[i].ed1; e.b = vecs[i].eb; e.e = vecs[i].ee;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      nm = $sformatf("v%0d", e.idx);
      chk({nm, "_d0"},   {32'h0, rd_data_a[31:0]},  {32'h0, e.d0});
      chk({nm, "_d1"},   {32'h0, rd_data_a[63:32]}, {32'h0, e.d1});
      chk({nm, "_busy"}, {62'h0, rd_busy_a},        {62'h0, e.b});
      chk({nm, "_err"},  {63'h0, sb_err_a},         {63'h0, e.e});
    end

    // Fill r1..r31 with their index and mark r2, r9, r31 busy.
    for (int i = 1; i < 32; i++) begin
      @(posedge clk); #1;
      idle_a();
      w0_en_a = 1; w0_addr_a = 5'(i); w0_data_a = 32'(i);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      idle_a();
      set_en_a = 1;
      set_addr_a = (i == 0) ? 5'd2 : (i == 1) ? 5'd9 : 5'd31;
    end
    @(posedge clk); #1;
    idle_a();
    rd_addr_a = {5'd9, 5'd31};
    @(negedge clk);
    chk("fill_r31", {32'h0, rd_data_a[31:0]},  64'd31);
    chk("fill_r9",  {32'h0, rd_data_a[63:32]}, 64'd9);
    chk("fill_busy", {62'h0, rd_busy_a}, 64'h3);

    // Reset asserted mid-cycle with a write and a set in flight.
    @(posedge clk); #1;
    w0_en_a = 1; w0_addr_a = 5'd4; w0_data_a = 32'hAAAA;
    set_en_a = 1; set_addr_a = 5'd4;
    #2;
    clrn_a = 0;
    #1;
    chk("rsta_err", {63'h0, sb_err_a}, 64'h0);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = {5'(31 - i), 5'(i)};
      #1;
      chk($sformatf("rsta_r%0d_data", i), rd_data_a, 64'h0);
      chk($sformatf("rsta_r%0d_busy", i), {62'h0, rd_busy_a}, 64'h0);
    end
    idle_a();
    @(negedge clk);
    clrn_a = 1;
    rd_addr_a = {5'd31, 5'd4};
    #1;
    chk("post_rst_data", rd_data_a, 64'h0);
    chk("post_rst_busy", {62'h0, rd_busy_a}, 64'h0);
    // First edge after release operates normally.
    @(posedge clk); #1;
    w0_en_a = 1; w0_addr_a = 5'd4; w0_data_a = 32'h5;
    @(posedge clk); #1;
    idle_a();
    @(negedge clk);
    chk("post_rst_wr", {32'h0, rd_data_a[31:0]}, 64'h5);

    // Instance B: fill r1..r15 with i*0x0101, set r15, then r5 twice.
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      idle_b();
      w0_en_b = 1; w0_addr_b = 4'(i); w0_data_b = 16'(i * 16'h0101);
    end
    @(posedge clk); #1; idle_b(); set_en_b = 1; set_addr_b = 4'd15;
    @(posedge clk); #1; idle_b(); set_en_b = 1; set_addr_b = 4'd5;
    @(posedge clk); #1; idle_b(); set_en_b = 1; set_addr_b = 4'd5;
    @(posedge clk); #1; idle_b();
    rd_addr_b = {4'd0, 4'd1, 4'd15, 4'd5};
    @(negedge clk);
    chk("b_data", rd_data_b, 64'h0000_0101_0F0F_0505);
    chk("b_busy", {60'h0, rd_busy_b}, 64'h3);
    chk("b_err",  {63'h0, sb_err_b}, 64'h1);
    #2;
    clrn_b = 0;
    #1;
    chk("rstb_err", {63'h0, sb_err_b}, 64'h0);
    for (int i = 0; i < 16; i++) begin
      rd_addr_b = {4'(i + 3), 4'(i + 2), 4'(i + 1), 4'(i)};
      #1;
      chk($sformatf("rstb_r%0d_data", i), rd_data_b, 64'h0);
      chk($sformatf("rstb_r%0d_busy", i), {60'h0, rd_busy_b}, 64'h0);
    end
    @(negedge clk);
    clrn_b = 1;
    #1;
    chk("b_post_data", rd_data_b, 64'h0);
    chk("b_post_err",  {63'h0, sb_err_b}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count; power of 2, 8..64; AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports, 1..4.
REQ-004 SHALL have clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have clrn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have rd_addr  input  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
REQ-007 SHALL have rd_data  output  NRD*DATA_W  packed read data.
REQ-008 SHALL have rd_busy  output  NRD  per-port flag: addressed register has a pending load.
REQ-009 SHALL have w0_en / w0_addr / w0_data  input  1 / AW / DATA_W  ALU write port.
REQ-010 SHALL have w1_en / w1_addr / w1_data  input  1 / AW / DATA_W  load-writeback port; also clears busy.
REQ-011 SHALL have sb_set_en / sb_set_addr  input  1 / AW  marks a register busy when a load issues.
REQ-012 SHALL have sb_err  output  1  registered one-cycle pulse: sb_set hit an already-busy register.

Function
REQ-013 SHALL read register 0 as 0 on every port; writes to 0 SHALL be ignored; register 0 SHALL never be busy.
REQ-014 SHALL read combinationally, write-first: if w0 or w1 targets the read address in the same cycle, rd_data SHALL be the data being written.
REQ-015 SHALL, when w0 and w1 target the same nonzero register in one cycle, store w0_data and bypass w0_data on reads.
REQ-016 SHALL commit writes at the rising edge; the stored value SHALL be visible from the next cycle without bypass.
REQ-017 SHALL set busy[sb_set_addr] at the edge when sb_set_en=1 and sb_set_addr!=0.
REQ-018 SHALL clear busy[w1_addr] at the edge when w1_en=1, regardless of the w0/w1 data priority.
REQ-019 SHALL let set win when sb_set and w1 clear target the same register in one cycle; busy SHALL be 1 afterwards.
REQ-020 SHALL drive rd_busy[k] = busy[addr_k] AND NOT (w1_en AND w1_addr==addr_k) AND addr_k!=0.
REQ-021 SHALL not clear busy on a w0 write.
REQ-022 SHALL pulse sb_err high for one cycle after an edge where sb_set_en=1 and the target was busy and not being cleared by w1 that cycle; busy stays 1.
REQ-023 SHALL have no other latency: reads 0 cycles, writes and busy updates 1 edge.

Reset
REQ-024 SHALL, while clrn=0, clear all registers to 0, all busy bits to 0 and sb_err to 0, independent of clk.
REQ-025 SHALL discard any write or sb_set coincident with reset assertion; the first edge after release SHALL operate normally.
REQ-026 SHALL output rd_data=0 and rd_busy=0 on every port during reset.

Structure
REQ-027 SHALL take AW derivation (clog2 function) and port-packing width constants from shared package regfile_pkg.
REQ-028 SHALL use one sub-module, regfile_rdport (address in, bypass mux, data and busy out), instantiated NRD times in a generate loop.
REQ-029 SHALL hold the busy vector (NREG bits, bit 0 tied 0) and the sb_err flop in the top level.

Verification
REQ-030 SHALL test: w0 writes 0xDEADBEEF to r5; same cycle rd_addr0=5 -> rd_data0=0xDEADBEEF (bypass); next cycle still 0xDEADBEEF.
REQ-031 SHALL test: w0 writes 0x11 and w1 writes 0x22 to r7 in one cycle -> r7=0x11; busy[7] cleared if previously set.
REQ-032 SHALL test: sb_set r3 -> rd_busy=1 next cycle; w1 to r3 -> rd_busy=0 in that same cycle and rd_data=w1_data.
REQ-033 SHALL test: sb_set r3 while r3 busy -> sb_err=1 one cycle later for exactly one cycle; sb_set r3 plus w1 r3 same cycle -> busy stays 1, no sb_err.
REQ-034 SHALL test: write 0xFFFFFFFF to r0 and sb_set r0 -> reads 0, rd_busy=0, no sb_err.
REQ-035 SHALL test: fill r1..r31 with i, set several busy bits, pulse clrn low mid-cycle -> all reads 0, all rd_busy 0 immediately; repeat with NRD=4, NREG=16, DATA_W=16.
